// File: rtl/bootrom_arb_pkg.sv
// Shared types and helpers for the boot ROM arbiter: the in-flight tracking
// record and the ROM address range check.
package bootrom_arb_pkg;

    // Width of the requester id carried through the response pipe (up to 16 ports).
    localparam int unsigned ID_W = 4;

    // First ROM word index decoded by the arbiter; the ROM starts at byte address 0.
    localparam logic [60:0] ROM_BASE_WORD_IDX = 61'd0;

    // One in-flight access: response owed to port 'id', with 'err' for range misses.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } inflight_t;

    // True when the word index addr[63:3] falls inside [BASE, BASE + rom_words).
    // addr[2:0] is a byte offset within the word and does not take part.
    function automatic logic in_range(input logic [63:0] addr, input logic [60:0] rom_words);
        logic [61:0] off_v;
        off_v = {1'b0, addr[63:3]} - {1'b0, ROM_BASE_WORD_IDX};
        if (off_v[61]) begin
            return 1'b0;
        end else begin
            return (off_v[60:0] < rom_words);
        end
    endfunction

endpackage

// File: rtl/bootrom_rr_arb.sv
// Parametric round-robin arbiter: picks the first requesting port at or after
// the pointer, wrapping around. Purely combinational; the pointer lives in
// the caller.
module bootrom_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   win_idx,
    output logic               valid
);

    int               ptr_s;
    int               cand_s;
    logic [IDX_W-1:0] cand_idx_s;

    // Scan ports starting at the pointer and grant the first requester found.
    always_comb begin
        gnt        = '0;
        win_idx    = '0;
        valid      = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        // An out-of-range pointer can only come from a corrupted register; restart at 0.
        if (int'(ptr) < NUM_REQ) begin
            ptr_s = int'(ptr);
        end else begin
            ptr_s = 0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = ptr_s + i;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!valid && req[cand_idx_s]) begin
                gnt[cand_idx_s] = 1'b1;
                win_idx         = cand_idx_s;
                valid           = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/bootrom_arbiter.sv
// Boot ROM arbiter: shares the single-ported boot ROM between NUM_REQ
// requesters with same-cycle round-robin grants, a range check that turns
// misses into error responses, and a fixed-latency in-flight pipe that routes
// each response back to the port that was granted.
module bootrom_arbiter
    import bootrom_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int ROM_WORDS = 1024,
    parameter int READ_LAT  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic                      rerr_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      rom_req_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_rdata_i
);

    localparam int          IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [60:0] ROM_WORDS_L = 61'(ROM_WORDS);

    logic [IDX_W-1:0]   ptr_r;
    logic [NUM_REQ-1:0] gnt_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               any_gnt_s;
    logic [ADDR_W-1:0]  win_addr_s;
    logic               win_in_range_s;
    inflight_t          new_entry_s;
    inflight_t          head_s;
    inflight_t          pipe_r [READ_LAT];

    bootrom_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req     (req_i),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .win_idx (win_idx_s),
        .valid   (any_gnt_s)
    );

    // Select the granted port's address (grant is one-hot or zero).
    always_comb begin
        win_addr_s = '0;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (gnt_s[p]) begin
                win_addr_s = addr_i[p*ADDR_W +: ADDR_W];
            end else begin
                win_addr_s = win_addr_s;
            end
        end
    end

    // Range-check the winner and drive the ROM strobe; misses never reach the ROM.
    always_comb begin
        win_in_range_s = in_range(64'(win_addr_s), ROM_WORDS_L);
        gnt_o          = gnt_s;
        if (any_gnt_s && win_in_range_s) begin
            rom_req_o  = 1'b1;
            rom_addr_o = win_addr_s;
        end else begin
            rom_req_o  = 1'b0;
            rom_addr_o = '0;
        end
    end

    // Advance the round-robin pointer past the winner; hold it when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r <= '0;
        end else if (any_gnt_s) begin
            if (win_idx_s == IDX_W'(NUM_REQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= win_idx_s + IDX_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Build the tracking record for this cycle's grant (empty when nothing granted).
    always_comb begin
        new_entry_s       = '0;
        new_entry_s.valid = any_gnt_s;
        new_entry_s.id    = ID_W'(win_idx_s);
        new_entry_s.err   = any_gnt_s & ~win_in_range_s;
    end

    // Shift the in-flight pipe every cycle so each record surfaces exactly READ_LAT later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= new_entry_s;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Route the oldest record to its port; data and error are zero outside a response.
    always_comb begin
        head_s   = pipe_r[READ_LAT-1];
        rvalid_o = '0;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (head_s.valid && (head_s.id == ID_W'(p))) begin
                rvalid_o[p] = 1'b1;
            end else begin
                rvalid_o[p] = 1'b0;
            end
        end
        rerr_o = head_s.valid & head_s.err;
        if (head_s.valid && !head_s.err) begin
            rdata_o = rom_rdata_i;
        end else begin
            rdata_o = '0;
        end
    end

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Bench for bootrom_arbiter: a 2-port READ_LAT=1 instance and a 3-port
// READ_LAT=3 instance, driven from a vector table, with responses checked
// against a per-instance scoreboard queue.
module tb_bootrom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: NUM_REQ=2, READ_LAT=1
    logic [1:0]   req_a;
    logic [127:0] addr_a;
    logic [1:0]   gnt_a, rvalid_a;
    logic         rerr_a, rom_req_a;
    logic [63:0]  rdata_a, rom_addr_a, rom_rdata_a;

    // Instance B: NUM_REQ=3, READ_LAT=3
    logic [2:0]   req_b;
    logic [191:0] addr_b;
    logic [2:0]   gnt_b, rvalid_b;
    logic         rerr_b, rom_req_b;
    logic [63:0]  rdata_b, rom_addr_b, rom_rdata_b;
    logic [63:0]  rom_p1_b, rom_p2_b;

    bootrom_arbiter #(.NUM_REQ(2), .ADDR_W(64), .DATA_W(64), .ROM_WORDS(1024), .READ_LAT(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .addr_i(addr_a), .gnt_o(gnt_a),
        .rvalid_o(rvalid_a), .rerr_o(rerr_a), .rdata_o(rdata_a), .rom_req_o(rom_req_a),
        .rom_addr_o(rom_addr_a), .rom_rdata_i(rom_rdata_a));

    bootrom_arbiter #(.NUM_REQ(3), .ADDR_W(64), .DATA_W(64), .ROM_WORDS(1024), .READ_LAT(3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .addr_i(addr_b), .gnt_o(gnt_b),
        .rvalid_o(rvalid_b), .rerr_o(rerr_b), .rdata_o(rdata_b), .rom_req_o(rom_req_b),
        .rom_addr_o(rom_addr_b), .rom_rdata_i(rom_rdata_b));

    // ROM contents: each word encodes its own index.
    function automatic logic [63:0] rom_word(input logic [9:0] idx);
        return {16'hB007, 22'h0, idx, 16'hC0DE};
    endfunction

    // ROM models with the matching read latency.
    always @(posedge clk) rom_rdata_a <= rom_word(rom_addr_a[12:3]);
    always @(posedge clk) begin
        rom_p1_b    <= rom_word(rom_addr_b[12:3]);
        rom_p2_b    <= rom_p1_b;
        rom_rdata_b <= rom_p2_b;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          dut;
        logic [2:0]  req;
        logic [63:0] a0, a1, a2;
        logic [2:0]  gnt;
        logic        rom_req;
        logic [63:0] rom_addr;
    } vec_t;

    typedef struct {
        logic [2:0]  port;
        logic        err;
        logic [63:0] data;
        int          due;
    } rsp_t;

    rsp_t q_a[$];
    rsp_t q_b[$];
    vec_t vecs[$];

    function automatic vec_t mk(input int dut, input logic [2:0] req, input logic [63:0] a0,
                                input logic [63:0] a1, input logic [63:0] a2, input logic [2:0] gnt,
                                input logic rr, input logic [63:0] ra);
        vec_t v;
        v.dut = dut; v.req = req; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.gnt = gnt; v.rom_req = rr; v.rom_addr = ra;
        return v;
    endfunction

    // Drive one vector for one cycle, check the same-cycle outputs, and queue the response.
    task automatic apply_vec(input vec_t v, input string name);
        rsp_t r;
        if (v.dut == 0) begin
            req_a = v.req[1:0]; addr_a = {v.a1, v.a0}; req_b = 3'b000;
        end else begin
            req_b = v.req; addr_b = {v.a2, v.a1, v.a0}; req_a = 2'b00;
        end
        @(negedge clk);
        if (v.dut == 0) begin
            check({name, "_gnt"},      {62'd0, gnt_a},     {61'd0, v.gnt});
            check({name, "_rom_req"},  {63'd0, rom_req_a}, {63'd0, v.rom_req});
            check({name, "_rom_addr"}, rom_addr_a,         v.rom_addr);
        end else begin
            check({name, "_gnt"},      {61'd0, gnt_b},     {61'd0, v.gnt});
            check({name, "_rom_req"},  {63'd0, rom_req_b}, {63'd0, v.rom_req});
            check({name, "_rom_addr"}, rom_addr_b,         v.rom_addr);
        end
        if (v.gnt != 3'b000) begin
            r.port = v.gnt;
            r.err  = !v.rom_req;
            r.data = r.err ? 64'd0 : rom_word(v.rom_addr[12:3]);
            r.due  = cyc + ((v.dut == 0) ? 1 : 3);
            if (v.dut == 0) q_a.push_back(r); else q_b.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every cycle, each instance must show either the due response or zeros.
    initial begin
        rsp_t ma, mb;
        forever begin
            @(negedge clk);
            ma = '{port: 3'b000, err: 1'b0, data: 64'd0, due: 0};
            mb = '{port: 3'b000, err: 1'b0, data: 64'd0, due: 0};
            if (q_a.size() > 0 && q_a[0].due == cyc) ma = q_a.pop_front();
            if (q_b.size() > 0 && q_b[0].due == cyc) mb = q_b.pop_front();
            check("a_rvalid", {62'd0, rvalid_a}, {61'd0, ma.port});
            check("a_rerr",   {63'd0, rerr_a},   {63'd0, ma.err});
            check("a_rdata",  rdata_a,           ma.data);
            check("b_rvalid", {61'd0, rvalid_b}, {61'd0, mb.port});
            check("b_rerr",   {63'd0, rerr_b},   {63'd0, mb.err});
            check("b_rdata",  rdata_b,           mb.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_a = 2'b00; addr_a = '0; req_b = 3'b000; addr_b = '0;
        @(negedge clk);
        check("rst_gnt_a",     {62'd0, gnt_a},     64'd0);
        check("rst_rom_req_a", {63'd0, rom_req_a}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: no grants, no ROM strobes.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_gnt_a",      {62'd0, gnt_a},     64'd0);
            check("idle_gnt_b",      {61'd0, gnt_b},     64'd0);
            check("idle_rom_req_a",  {63'd0, rom_req_a}, 64'd0);
            check("idle_rom_req_b",  {63'd0, rom_req_b}, 64'd0);
            check("idle_rom_addr_a", rom_addr_a,         64'd0);
        end
        @(posedge clk);
        #1;

        //            dut req     a0         a1                      a2        gnt     rr    rom_addr
        vecs.push_back(mk(0, 3'b001, 64'h8,    64'h0,                  64'h0,    3'b001, 1'b1, 64'h8));
        vecs.push_back(mk(0, 3'b010, 64'h0,    64'h2000,               64'h0,    3'b010, 1'b0, 64'h0));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(0, 3'b011, 64'h17, 64'h1FF8,             64'h0,    3'b001, 1'b1, 64'h17));
            vecs.push_back(mk(0, 3'b011, 64'h17, 64'h1FF8,             64'h0,    3'b010, 1'b1, 64'h1FF8));
        end
        vecs.push_back(mk(0, 3'b010, 64'h0,    64'h8000_0000_0000_0000, 64'h0,   3'b010, 1'b0, 64'h0));
        vecs.push_back(mk(0, 3'b000, 64'h8,    64'h8,                  64'h0,    3'b000, 1'b0, 64'h0));
        vecs.push_back(mk(0, 3'b010, 64'h0,    64'h1FF8,               64'h0,    3'b010, 1'b1, 64'h1FF8));
        vecs.push_back(mk(0, 3'b011, 64'h0,    64'h8,                  64'h0,    3'b001, 1'b1, 64'h0));
        vecs.push_back(mk(0, 3'b011, 64'h0,    64'h1FFF,               64'h0,    3'b010, 1'b1, 64'h1FFF));
        vecs.push_back(mk(0, 3'b001, 64'h2008, 64'h0,                  64'h0,    3'b001, 1'b0, 64'h0));
        vecs.push_back(mk(1, 3'b111, 64'h0,    64'h20,                 64'h28,   3'b001, 1'b1, 64'h0));
        vecs.push_back(mk(1, 3'b111, 64'h0,    64'h20,                 64'h28,   3'b010, 1'b1, 64'h20));
        vecs.push_back(mk(1, 3'b111, 64'h0,    64'h20,                 64'h28,   3'b100, 1'b1, 64'h28));
        vecs.push_back(mk(1, 3'b100, 64'h0,    64'h0,                  64'h30,   3'b100, 1'b1, 64'h30));
        vecs.push_back(mk(1, 3'b110, 64'h0,    64'h20,                 64'h30,   3'b010, 1'b1, 64'h20));
        vecs.push_back(mk(1, 3'b011, 64'h0,    64'h20,                 64'h30,   3'b001, 1'b1, 64'h0));
        vecs.push_back(mk(1, 3'b101, 64'h0,    64'h0,                  64'h2000, 3'b100, 1'b0, 64'h0));

        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));
        req_a = 2'b00; req_b = 3'b000;
        repeat (5) @(posedge clk);
        #1;

        // Reset one cycle before a READ_LAT=3 response is due: it must never appear.
        apply_vec(mk(1, 3'b001, 64'h40, 64'h0, 64'h0, 3'b001, 1'b1, 64'h40), "pre_rst");
        req_b = 3'b000;
        @(posedge clk);
        #1 rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        #1 check("in_rst_rvalid_b", {61'd0, rvalid_b}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Both pointers must be back at port 0.
        apply_vec(mk(0, 3'b011, 64'h48, 64'h50, 64'h0,  3'b001, 1'b1, 64'h48), "post_rst_a");
        apply_vec(mk(1, 3'b111, 64'h58, 64'h60, 64'h68, 3'b001, 1'b1, 64'h58), "post_rst_b");
        req_a = 2'b00; req_b = 3'b000;
        repeat (6) @(posedge clk);
        #1;

        check("drain_q_a", 64'(q_a.size()), 64'd0);
        check("drain_q_b", 64'(q_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
